// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and register-match helpers for the hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } trk_ex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
  } trk_t;

  // r0 is hardwired, so it never matches a producer.
  function automatic logic hits(input logic [REG_W-1:0] src,
                                input logic [REG_W-1:0] rd,
                                input logic             wr);
    return wr && (rd != '0) && (rd == src);
  endfunction

  // Newest producer wins: EX (next cycle in MEM) before MEM (next cycle in WB).
  function automatic logic [1:0] fwd_pick(input logic [REG_W-1:0] src,
                                          input logic [REG_W-1:0] ex_rd,
                                          input logic             ex_alu_wr,
                                          input logic [REG_W-1:0] mem_rd,
                                          input logic             mem_wr);
    if (hits(src, ex_rd, ex_alu_wr)) return FWD_MEM;
    if (hits(src, mem_rd, mem_wr))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_track_pipe.sv
// Destination tracking for EX, MEM and WB; a bubble replaces the ID capture when requested.
module hazard_track_pipe
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  output logic [REG_W-1:0] ex_rd_o,
  output logic             ex_wr_o,
  output logic             ex_ld_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             mem_wr_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic             wb_wr_o
);

  trk_ex_t ex_q, ex_d;
  trk_t    mem_q, mem_d;
  trk_t    wb_q;

  always_comb begin
    ex_d = '0;
    if (!bubble_i) begin
      ex_d.rd = id_rd_i;
      ex_d.wr = id_valid_i & id_reg_write_i;
      ex_d.ld = id_valid_i & id_mem_read_i;
    end
    // A load always writes its rd, so it becomes a writer once past EX.
    mem_d.rd = ex_q.rd;
    mem_d.wr = ex_q.wr | ex_q.ld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  assign ex_rd_o  = ex_q.rd;
  assign ex_wr_o  = ex_q.wr;
  assign ex_ld_o  = ex_q.ld;
  assign mem_rd_o = mem_q.rd;
  assign mem_wr_o = mem_q.wr;
  assign wb_rd_o  = wb_q.rd;
  assign wb_wr_o  = wb_q.wr;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation and EX operand forwarding selects.
// Define HAZARD_CTRL_FWD_EN for forwarding with load-use stalls; otherwise interlock-only.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        br_taken_ex,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [15:0] stall_cnt
);

  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ex_wr, ex_ld, mem_wr, wb_wr;
  hz_state_e        state_q, state_d;
  logic             hazard;
  logic [15:0]      cnt_q, cnt_d;

  hazard_track_pipe u_track (
    .clk            (clk),
    .rst            (rst),
    .bubble_i       (stall | flush),
    .id_valid_i     (id_valid),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .ex_rd_o        (ex_rd),
    .ex_wr_o        (ex_wr),
    .ex_ld_o        (ex_ld),
    .mem_rd_o       (mem_rd),
    .mem_wr_o       (mem_wr),
    .wb_rd_o        (wb_rd),
    .wb_wr_o        (wb_wr)
  );

  assign flush = !rst && br_taken_ex;
  assign stall = !rst && !br_taken_ex && hazard;

`ifdef HAZARD_CTRL_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // A load-use stall lasts one cycle: in STALL the EX slot already holds the bubble.
  always_comb begin
    hazard = id_valid && ex_ld && (state_q == RUN) &&
             (hits(id_rs, ex_rd, 1'b1) || (id_uses_rt && hits(id_rt, ex_rd, 1'b1)));
  end

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!(stall || flush)) begin
      fwd_a_d = fwd_pick(id_rs, ex_rd, ex_wr & ~ex_ld, mem_rd, mem_wr);
      if (id_uses_rt)
        fwd_b_d = fwd_pick(id_rt, ex_rd, ex_wr & ~ex_ld, mem_rd, mem_wr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  logic dep_rs, dep_rt;

  // Interlock until the producer reaches WB; in STALL the EX slot is a bubble.
  always_comb begin
    dep_rs = ((state_q == RUN) && hits(id_rs, ex_rd, ex_wr | ex_ld)) ||
             hits(id_rs, mem_rd, mem_wr);
    dep_rt = ((state_q == RUN) && hits(id_rt, ex_rd, ex_wr | ex_ld)) ||
             hits(id_rt, mem_rd, mem_wr);
    hazard = id_valid && (dep_rs || (id_uses_rt && dep_rt));
  end

  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall)  state_d = STALL;
      STALL:   if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

`ifndef SYNTHESIS
  // A forwarded operand must have a live producer in the stage it is taken from.
  always_ff @(posedge clk) begin
    if (!rst && (fwd_a_sel == FWD_WB || fwd_b_sel == FWD_WB))
      assert (wb_wr && (wb_rd != '0));
    if (!rst && (fwd_a_sel == FWD_MEM || fwd_b_sel == FWD_MEM))
      assert (mem_wr && (mem_rd != '0));
  end
`endif

endmodule
